// File: rtl/arb_pkg.sv
// Shared types for the round-robin digit-unit arbiter.
// Error logic in arb_rr_digit is compiled in only when ARB_ERR_EN is defined.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LANE = 2'd1;
    localparam logic [1:0] ERR_SPUR = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr,
// wrapping around to lane 0.
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] pick,
    output logic [W-1:0] pick_id,
    output logic         any
);

    always_comb begin : pick_loop
        int unsigned idx;
        idx     = 0;
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!any && req[W'(idx)]) begin
                any            = 1'b1;
                pick[W'(idx)]  = 1'b1;
                pick_id        = W'(idx);
            end
        end
    end

endmodule

// File: rtl/arb_rr_digit.sv
// Round-robin arbiter sharing one digit-validation unit between N lanes.
// Define ARB_ERR_EN to build the sticky error reporting; otherwise err/err_code are 0.
module arb_rr_digit
    import arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         req_err,
    input  logic                 done,
    input  logic                 err_clr,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int unsigned W  = $clog2(N);
    localparam int unsigned CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);
    localparam logic [W-1:0]  LAST_ID = W'(N - 1);

    arb_state_t     r_state, w_state_nx;
    logic [N-1:0]   r_grant, w_grant_nx;
    logic [W-1:0]   r_grant_id, w_grant_id_nx;
    logic [W-1:0]   r_ptr, w_ptr_nx;
    logic [CW-1:0]  r_cnt, w_cnt_nx;

    logic [N-1:0]   w_pick;
    logic [W-1:0]   w_pick_id;
    logic           w_any;
    logic           w_at_max;

    rr_pick #(.N(N), .W(W)) u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .pick    (w_pick),
        .pick_id (w_pick_id),
        .any     (w_any)
    );

    assign w_at_max = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_grant_id <= w_grant_id_nx;
            r_ptr      <= w_ptr_nx;
            r_cnt      <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_grant_nx    = r_grant;
        w_grant_id_nx = r_grant_id;
        w_ptr_nx      = r_ptr;
        w_cnt_nx      = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nx    = HOLD;
                    w_grant_nx    = w_pick;
                    w_grant_id_nx = w_pick_id;
                    w_cnt_nx      = '0;
                end
            end
            HOLD: begin
                // Timeout release is identical to done, error reporting aside.
                if (done || w_at_max) begin
                    w_state_nx    = IDLE;
                    w_grant_nx    = '0;
                    w_grant_id_nx = '0;
                    w_ptr_nx      = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
                end else if (!w_at_max) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state == HOLD);

`ifdef ARB_ERR_EN
    logic       r_err;
    logic [1:0] r_err_code;
    logic [1:0] w_new_code;
    logic       w_tmo, w_lane, w_spur;

    assign w_tmo  = (r_state == HOLD) && w_at_max && !done;
    assign w_lane = (r_state == HOLD) && req_err[r_grant_id];
    assign w_spur = (r_state == IDLE) && done;

    always_comb begin
        w_new_code = ERR_NONE;
        if (w_tmo)       w_new_code = ERR_TMO;
        else if (w_lane) w_new_code = ERR_LANE;
        else if (w_spur) w_new_code = ERR_SPUR;
    end

    // First error is kept; a new error in the same cycle as err_clr is captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if ((w_new_code != ERR_NONE) && (!r_err || err_clr)) begin
            r_err      <= 1'b1;
            r_err_code <= w_new_code;
        end else if (err_clr) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end
    end

    assign err      = r_err;
    assign err_code = r_err_code;
`else
    logic w_unused_err;
    assign w_unused_err = ^{req_err, err_clr};
    assign err          = 1'b0;
    assign err_code     = ERR_NONE;
`endif

endmodule

// File: tb/tb_arb_rr_digit.sv
// Bench for arb_rr_digit: vector table, directed corner sequences and random traffic
// against a lane-ownership reference model. Error expectations follow ARB_ERR_EN.
module tb_arb_rr_digit;

    localparam int N    = 4;
    localparam int HMAX = 3;
`ifdef ARB_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, req_err;
    logic       done, err_clr;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       busy, err;
    logic [1:0] err_code;

    arb_rr_digit #(.N(N), .HOLD_MAX(HMAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_err     (req_err),
        .done        (done),
        .err_clr     (err_clr),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .busy        (busy),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: which lane owns the unit (-1 = none), cycles it has held, next search start.
    int m_owner, m_held, m_ptr, m_code;
    bit m_err;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] exp_grant;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_ptr = 0; m_err = 0; m_code = 0;
    endtask

    task automatic model_step();
        int  code;
        bit  found, tmo;
        code = 0;
        if (m_owner < 0) begin
            if (done) code = 2;
            found = 0;
            for (int k = 0; k < N; k++) begin
                int l;
                l = (m_ptr + k) % N;
                if (!found && req[l]) begin
                    found = 1; m_owner = l; m_held = 0;
                end
            end
        end else begin
            tmo = (m_held == HMAX) && !done;
            if (tmo) code = 3;
            else if (req_err[m_owner]) code = 1;
            if (done || tmo) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
        if (code != 0 && (!m_err || err_clr)) begin
            m_err = 1; m_code = code;
        end else if (err_clr) begin
            m_err = 0; m_code = 0;
        end
    endtask

    task automatic check_model(input string tag);
        int eg;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk({tag, ".grant"}, int'(grant), eg);
        chk({tag, ".grant_valid"}, int'(grant_valid), int'(m_owner >= 0));
        chk({tag, ".grant_id"}, int'(grant_id), (m_owner >= 0) ? m_owner : 0);
        chk({tag, ".busy"}, int'(busy), int'(m_owner >= 0));
        chk({tag, ".err"}, int'(err), ERR_ON ? int'(m_err) : 0);
        chk({tag, ".err_code"}, int'(err_code), ERR_ON ? m_code : 0);
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] re, input logic d,
                         input logic c, input string tag);
        req = r; req_err = re; done = d; err_clr = c;
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req = '0; req_err = '0; done = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.grant", int'(grant), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.err", int'(err), 0);
        chk("reset.err_code", int'(err_code), 0);
        reset = 1'b0;

        // req=0101 with done two cycles after grant, then a four-lane rotation.
        tbl[0]  = '{4'b0101, 1'b0, 4'b0001};
        tbl[1]  = '{4'b0101, 1'b0, 4'b0001};
        tbl[2]  = '{4'b0101, 1'b1, 4'b0000};
        tbl[3]  = '{4'b0101, 1'b0, 4'b0100};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000};
        tbl[5]  = '{4'b0000, 1'b0, 4'b0000};
        tbl[6]  = '{4'b1111, 1'b0, 4'b1000};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0000};
        tbl[8]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0000};
        tbl[10] = '{4'b1111, 1'b0, 4'b0010};
        tbl[11] = '{4'b1111, 1'b1, 4'b0000};
        tbl[12] = '{4'b1111, 1'b0, 4'b0100};
        tbl[13] = '{4'b1111, 1'b1, 4'b0000};
        tbl[14] = '{4'b1111, 1'b0, 4'b1000};
        tbl[15] = '{4'b1111, 1'b1, 4'b0000};
        tbl[16] = '{4'b1111, 1'b0, 4'b0001};
        tbl[17] = '{4'b0000, 1'b1, 4'b0000};
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].req, 4'b0000, tbl[i].done, 1'b0, "tbl");
            chk("tbl.exp_grant", int'(grant), int'(tbl[i].exp_grant));
        end

        // Lane 2 timeout with req dropped after grant: held 4 cycles then released.
        cycle(4'b0100, 4'b0000, 1'b0, 1'b0, "tmo");
        chk("tmo.grant0", int'(grant), 4);
        for (int i = 1; i < 4; i++) begin
            cycle(4'b0000, 4'b0000, 1'b0, 1'b0, "tmo");
            chk("tmo.held", int'(grant), 4);
        end
        cycle(4'b0000, 4'b0000, 1'b0, 1'b0, "tmo");
        chk("tmo.released", int'(grant), 0);
        chk("tmo.err", int'(err), int'(ERR_ON));
        chk("tmo.code", int'(err_code), ERR_ON ? 3 : 0);
        cycle(4'b0000, 4'b0000, 1'b0, 1'b1, "clr");
        chk("clr.err", int'(err), 0);

        // Spurious done in IDLE.
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0, "spur");
        chk("spur.grant", int'(grant), 0);
        chk("spur.err", int'(err), int'(ERR_ON));
        chk("spur.code", int'(err_code), ERR_ON ? 2 : 0);
        cycle(4'b0000, 4'b0000, 1'b0, 1'b0, "spur_hold");
        chk("spur.sticky", int'(err_code), ERR_ON ? 2 : 0);
        cycle(4'b0000, 4'b0000, 1'b0, 1'b1, "clr");

        // Lane 1: lane error coincides with timeout, timeout wins.
        cycle(4'b0010, 4'b0000, 1'b0, 1'b0, "coll");
        chk("coll.grant", int'(grant), 2);
        for (int i = 1; i < 4; i++) cycle(4'b0010, 4'b0000, 1'b0, 1'b0, "coll");
        cycle(4'b0000, 4'b0011, 1'b0, 1'b0, "coll");
        chk("coll.released", int'(grant), 0);
        chk("coll.code", int'(err_code), ERR_ON ? 3 : 0);
        cycle(4'b0000, 4'b0000, 1'b0, 1'b1, "coll_clr");
        chk("coll.clr", int'(err), 0);

        // Async reset mid-HOLD with a lane error already captured.
        cycle(4'b0001, 4'b0001, 1'b0, 1'b0, "rst");
        chk("rst.grant", int'(grant), 1);
        cycle(4'b0001, 4'b0001, 1'b0, 1'b0, "rst");
        chk("rst.code", int'(err_code), ERR_ON ? 1 : 0);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst.async_grant", int'(grant), 0);
        chk("rst.async_busy", int'(busy), 0);
        chk("rst.async_err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        cycle(4'b1000, 4'b0000, 1'b0, 1'b0, "post_rst");
        chk("post_rst.grant", int'(grant), 8);
        chk("post_rst.id", int'(grant_id), 3);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] r, re;
            logic       d, c;
            r  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            re = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            c  = ($urandom_range(0, 15) == 0);
            if (m_owner >= 0) begin
                d = ($urandom_range(0, 9) < 3);
            end else begin
                d = ($urandom_range(0, 19) == 0);
                if (d) r = 4'b0000;
            end
            cycle(r, re, d, c, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arb_rr_digit.md
# arb_rr_digit

Round-robin arbiter that shares one registered digit-validation/priority unit between N requesting residue lanes in the error-correcting TPU datapath. It grants exactly one requester at a time and holds the grant until the shared unit signals completion. It also folds requester error flags, protocol violations and a hold-timeout into a sticky error code, so error information propagates downstream the same way datapath errors do.

## Interface
- N, default 4: number of requesters; legal range 2..16.
- HOLD_MAX, default 15: maximum number of cycles a grant may be held before a forced release; legal range 1..255.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  request per lane; level-sensitive.
- req_err  in  N  error flag per lane; only the granted lane's bit is examined.
- done  in  1  one-cycle pulse from the shared unit: the current operation has finished.
- err_clr  in  1  clears the sticky error.
- grant  out  N  one-hot grant, registered.
- grant_valid  out  1  equals OR of grant.
- grant_id  out  $clog2(N)  index of the granted lane; 0 when there is no grant.
- busy  out  1  high when the FSM is in HOLD.
- err  out  1  sticky error flag.
- err_code  out  2  error code: 0 = none, 1 = lane error, 2 = spurious done, 3 = timeout.

## Operation
- FSM states: IDLE and HOLD.
- IDLE with req != 0:
  - Pick the first set req bit, searching from ptr upward with wrap-around.
  - Register the grant and go to HOLD.
  - Reset the hold counter to 0.
- HOLD:
  - Hold counter increments by 1 each cycle. Counter width is $clog2(HOLD_MAX+1); it saturates and never wraps.
  - done=1: go to IDLE, clear grant, set ptr = (grant_id+1) mod N.
  - Counter == HOLD_MAX and done=0: forced release, handled exactly like done; also raise error code 3.
  - req[grant_id] dropping while in HOLD does not revoke the grant. Release happens only on done or timeout.
  - req_err[grant_id]=1 in any HOLD cycle raises error code 1.
- done=1 while in IDLE raises error code 2. The FSM stays in IDLE and ptr is unchanged.
- Sticky error behaviour:
  - The first error wins. While err=1, later errors do not change err_code.
  - If error sources collide in the same cycle, the priority is 3 > 1 > 2.
  - err_clr clears err and err_code on the next edge.
  - If err_clr and a new error occur in the same cycle, the new error is captured (set wins).
- ptr resets to 0. Lanes with no request are skipped, so the arbiter is starvation-free for persistently asserted requests.

## Timing
- Reset values: grant=0, grant_valid=0, grant_id=0, busy=0, err=0, err_code=0, ptr=0, state=IDLE, counter=0.
- Reset asserted mid-HOLD drops the grant immediately (asynchronously). No done is expected afterwards.
- Request-to-grant latency: 1 cycle. A req seen at edge k produces a grant visible after edge k+1.
- Done-to-release latency: 1 cycle. There is a mandatory one-cycle IDLE bubble between consecutive grants, so the earliest re-grant is 2 cycles after done.
- Timeout: with no done, the grant is held for HOLD_MAX+1 cycles and released on the following edge.
- Error outputs are registered with 1-cycle latency from the triggering condition.

## Configuration
- ARB_ERR_EN defined:
  - Full error logic is present: req_err monitoring, spurious-done detection, timeout error reporting, sticky err/err_code, err_clr.
- ARB_ERR_EN undefined:
  - err and err_code are tied to 0 and err_clr is ignored.
  - Timeout forced release still occurs, so arbitration behaviour is identical.

## Structure
- Package arb_pkg holds:
  - the state enum (IDLE, HOLD);
  - the error-code localparams ERR_NONE, ERR_LANE, ERR_SPUR, ERR_TMO.
- Sub-module rr_pick: a combinational rotate-priority picker.
  - Inputs: req[N], ptr.
  - Outputs: one-hot pick[N], pick_id, any.
  - Instantiated once; all state stays in arb_rr_digit.

## Test plan
- Reset, then req=4'b0101, done two cycles after the grant:
  - grant=0001 one cycle after req;
  - after done, grant=0 and then grant=0100;
  - ptr ends at 3.
- All four lanes requesting continuously, done 1 cycle after each grant:
  - grant order 0001, 0010, 0100, 1000, 0001;
  - one idle cycle between grants.
- HOLD_MAX=3, lane 2 granted, done never asserted:
  - grant held for 4 cycles, then released;
  - err=1, err_code=3.
- done pulse while IDLE with req=0:
  - err=1, err_code=2;
  - grant stays 0.
- Lane 1 granted with req_err=4'b0011 on the same cycle as the timeout:
  - err_code=3 (timeout beats lane error);
  - a later err_clr clears err to 0.
- Assert reset during HOLD:
  - grant, busy and err go to 0 immediately;
  - after reset releases, req=1000 is granted to lane 3.
